// File: rtl/vu_vmu_dcache_arb_if.sv
// vu_vmu_dcache_arb_if: LRQ/SRQ dequeue ports and the VMU D$ request/response port.
// Ports (signals): lrq_deq_* (load request), srq_deq_* (store/AMO request),
// dcachereq_* (D$ request), dcacheresp_val (D$ response strobe).
// slave = the arbiter, master = the surrounding queues and D$.
interface vu_vmu_dcache_arb_if;
    logic        lrq_deq_val;
    logic        lrq_deq_rdy;
    logic [29:0] lrq_deq_addr_bits;
    logic [11:0] lrq_deq_tag_bits;
    logic        srq_deq_val;
    logic        srq_deq_rdy;
    logic [29:0] srq_deq_addr_bits;
    logic [11:0] srq_deq_tag_bits;
    logic [3:0]  srq_deq_op_bits;
    logic [7:0]  srq_deq_wmask_bits;
    logic [63:0] srq_deq_data_bits;
    logic        dcachereq_val;
    logic        dcachereq_rdy;
    logic [29:0] dcachereq_addr;
    logic [11:0] dcachereq_tag;
    logic [3:0]  dcachereq_op;
    logic [7:0]  dcachereq_wmask;
    logic [63:0] dcachereq_data;
    logic        dcacheresp_val;
    modport slave (
        input  lrq_deq_val, lrq_deq_addr_bits, lrq_deq_tag_bits,
        input  srq_deq_val, srq_deq_addr_bits, srq_deq_tag_bits, srq_deq_op_bits,
        input  srq_deq_wmask_bits, srq_deq_data_bits, dcachereq_rdy, dcacheresp_val,
        output lrq_deq_rdy, srq_deq_rdy, dcachereq_val, dcachereq_addr, dcachereq_tag,
        output dcachereq_op, dcachereq_wmask, dcachereq_data
    );
    modport master (
        output lrq_deq_val, lrq_deq_addr_bits, lrq_deq_tag_bits,
        output srq_deq_val, srq_deq_addr_bits, srq_deq_tag_bits, srq_deq_op_bits,
        output srq_deq_wmask_bits, srq_deq_data_bits, dcachereq_rdy, dcacheresp_val,
        input  lrq_deq_rdy, srq_deq_rdy, dcachereq_val, dcachereq_addr, dcachereq_tag,
        input  dcachereq_op, dcachereq_wmask, dcachereq_data
    );
endinterface

// File: rtl/vu_vmu_dcache_arb.sv
// vu_vmu_dcache_arb: shares the VMU D$ request port between LRQ and SRQ with store
// priority, load anti-starvation and a credit limit on response-bearing requests.
// Ports: clk, reset (sync, active-high), bus (arbiter side of the LRQ/SRQ/D$ interface),
// arb_idle (all credits home, no queue valid), credit_err (sticky unexpected response).
module vu_vmu_dcache_arb #(
    parameter int         MAX_OUTST  = 8,
    parameter int         CRED_W     = 4,
    parameter int         STARVE_LIM = 4,
    parameter logic [3:0] OP_ST      = 4'b0001
) (
    input  logic                clk,
    input  logic                reset,
    vu_vmu_dcache_arb_if.slave  bus,
    output logic                arb_idle,
    output logic                credit_err
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [CRED_W-1:0] CMAX = CRED_W'(MAX_OUTST);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIM);
    logic [CRED_W-1:0] credits, credits_next;
    logic [SW-1:0] starve_cnt, starve_next;
    logic need_resp_s, ld_ok, st_ok, sel_ld, sel_st, fire, take, resp_ovf;
    always_comb begin
        need_resp_s = bus.srq_deq_op_bits != OP_ST;
        ld_ok = bus.lrq_deq_val && credits != '0;
        st_ok = bus.srq_deq_val && (!need_resp_s || credits != '0);
        sel_ld = ld_ok && (starve_cnt == SLIM || !st_ok);
        sel_st = st_ok && !sel_ld;
        fire = (sel_ld || sel_st) && bus.dcachereq_rdy;
        take = fire && (sel_ld || need_resp_s);
        // A response with every credit already home is dropped and flagged.
        resp_ovf = bus.dcacheresp_val && !take && credits == CMAX;
        credits_next = resp_ovf ? credits
                     : credits - CRED_W'(take) + CRED_W'(bus.dcacheresp_val);
        // Saturates while credits are exhausted, so the load wins once one returns.
        starve_next = (bus.lrq_deq_val && !(sel_ld && fire))
                    ? (starve_cnt == SLIM ? starve_cnt : starve_cnt + SW'(1)) : '0;
    end
    assign bus.dcachereq_val   = sel_ld || sel_st;
    assign bus.lrq_deq_rdy     = sel_ld && bus.dcachereq_rdy;
    assign bus.srq_deq_rdy     = sel_st && bus.dcachereq_rdy;
    assign bus.dcachereq_addr  = sel_st ? bus.srq_deq_addr_bits : bus.lrq_deq_addr_bits;
    assign bus.dcachereq_tag   = sel_st ? bus.srq_deq_tag_bits : bus.lrq_deq_tag_bits;
    assign bus.dcachereq_op    = sel_st ? bus.srq_deq_op_bits : 4'b0000;
    assign bus.dcachereq_wmask = sel_st ? bus.srq_deq_wmask_bits : 8'h00;
    assign bus.dcachereq_data  = bus.srq_deq_data_bits;
    assign arb_idle = credits == CMAX && !bus.lrq_deq_val && !bus.srq_deq_val;
    always_ff @(posedge clk) begin
        if (reset) begin
            credits    <= CMAX;
            starve_cnt <= '0;
            credit_err <= 1'b0;
        end else begin
            credits    <= credits_next;
            starve_cnt <= starve_next;
            credit_err <= credit_err || resp_ovf;
        end
    end
endmodule

// File: tb/tb_vu_vmu_dcache_arb.sv
// tb_vu_vmu_dcache_arb: scoreboard bench with directed scenarios and random traffic.
module tb_vu_vmu_dcache_arb;
    logic clk = 1'b0;
    logic reset;
    logic arb_idle, credit_err;
    always #5 clk = ~clk;
    vu_vmu_dcache_arb_if bus();
    vu_vmu_dcache_arb dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .arb_idle(arb_idle),
        .credit_err(credit_err)
    );
    typedef struct {
        logic        val, lrdy, srdy, st, idle, err;
        logic [29:0] addr;
        logic [11:0] tag;
        logic [3:0]  op;
        logic [7:0]  wmask;
        logic [63:0] data;
    } exp_t;
    exp_t sbq[$];
    int checks = 0, failures = 0, ld_fires = 0, st_fires = 0;
    int outst = 0, waited = 0;
    bit err_m = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("req_val", 64'(bus.dcachereq_val), 64'(e.val));
            chk("lrq_rdy", 64'(bus.lrq_deq_rdy), 64'(e.lrdy));
            chk("srq_rdy", 64'(bus.srq_deq_rdy), 64'(e.srdy));
            chk("arb_idle", 64'(arb_idle), 64'(e.idle));
            chk("credit_err", 64'(credit_err), 64'(e.err));
            if (e.val) begin
                chk("req_addr", 64'(bus.dcachereq_addr), 64'(e.addr));
                chk("req_tag", 64'(bus.dcachereq_tag), 64'(e.tag));
                chk("req_op", 64'(bus.dcachereq_op), 64'(e.op));
                chk("req_wmask", 64'(bus.dcachereq_wmask), 64'(e.wmask));
                if (e.st) chk("req_data", bus.dcachereq_data, e.data);
            end
            if (bus.lrq_deq_rdy === 1'b1) ld_fires++;
            if (bus.srq_deq_rdy === 1'b1) st_fires++;
        end
    end
    // Reference model: outst counts response-bearing requests in flight, waited counts
    // cycles a valid load has gone unserved; the arbitration rules are applied directly.
    task automatic step(input bit lv, input bit sv, input logic [3:0] op,
                        input bit rdy, input bit resp, input bit rs);
        exp_t e;
        bit need, ld_ok, st_ok, pl, ps, fired, took;
        bus.lrq_deq_val = lv;
        bus.lrq_deq_addr_bits = 30'($urandom);
        bus.lrq_deq_tag_bits = 12'($urandom);
        bus.srq_deq_val = sv;
        bus.srq_deq_addr_bits = 30'($urandom);
        bus.srq_deq_tag_bits = 12'($urandom);
        bus.srq_deq_op_bits = op;
        bus.srq_deq_wmask_bits = 8'($urandom);
        bus.srq_deq_data_bits = {$urandom, $urandom};
        bus.dcachereq_rdy = rdy;
        bus.dcacheresp_val = resp;
        reset = rs;
        need = op != 4'b0001;
        ld_ok = lv && outst < 8;
        st_ok = sv && (!need || outst < 8);
        pl = ld_ok && (waited >= 4 || !st_ok);
        ps = st_ok && !pl;
        e.val = pl || ps;
        e.lrdy = pl && rdy;
        e.srdy = ps && rdy;
        e.st = ps;
        e.idle = outst == 0 && !lv && !sv;
        e.err = err_m;
        e.addr = ps ? bus.srq_deq_addr_bits : bus.lrq_deq_addr_bits;
        e.tag = ps ? bus.srq_deq_tag_bits : bus.lrq_deq_tag_bits;
        e.op = ps ? op : 4'h0;
        e.wmask = ps ? bus.srq_deq_wmask_bits : 8'h00;
        e.data = bus.srq_deq_data_bits;
        sbq.push_back(e);
        if (rs) begin
            outst = 0;
            waited = 0;
            err_m = 0;
        end else begin
            fired = e.val && rdy;
            took = fired && (pl || need);
            if (resp && !took && outst == 0) err_m = 1;
            else outst = outst + int'(took) - int'(resp);
            waited = (lv && !(pl && fired)) ? (waited >= 4 ? 4 : waited + 1) : 0;
        end
        @(posedge clk);
        #1;
    endtask
    initial begin : stim
        int b_ld, b_st;
        logic [3:0] rop;
        bus.lrq_deq_val = 0; bus.srq_deq_val = 0; bus.dcachereq_rdy = 0; bus.dcacheresp_val = 0;
        bus.lrq_deq_addr_bits = 0; bus.lrq_deq_tag_bits = 0; bus.srq_deq_addr_bits = 0;
        bus.srq_deq_tag_bits = 0; bus.srq_deq_op_bits = 0; bus.srq_deq_wmask_bits = 0;
        bus.srq_deq_data_bits = 0;
        reset = 1;
        @(posedge clk);
        #1;
        step(0, 0, 4'h1, 1, 0, 1);
        // Credit limit: 8 loads fire, then one more after a single response.
        b_ld = ld_fires;
        for (int i = 0; i < 10; i++) step(1, 0, 4'h1, 1, 0, 0);
        chk("s1_eight_loads", 64'(ld_fires - b_ld), 64'd8);
        step(1, 0, 4'h1, 1, 1, 0);
        step(1, 0, 4'h1, 1, 0, 0);
        chk("s1_ninth_load", 64'(ld_fires - b_ld), 64'd9);
        // Starvation: four stores, then the waiting load, then stores again.
        step(0, 0, 4'h1, 1, 0, 1);
        b_ld = ld_fires; b_st = st_fires;
        for (int i = 0; i < 5; i++) step(1, 1, 4'h1, 1, 0, 0);
        chk("s2_stores_first", 64'(st_fires - b_st), 64'd4);
        chk("s2_load_wins", 64'(ld_fires - b_ld), 64'd1);
        step(1, 1, 4'h1, 1, 0, 0);
        chk("s2_store_resumes", 64'(st_fires - b_st), 64'd5);
        // Credits exhausted: plain store fires, AMO waits for a returned credit.
        step(0, 0, 4'h1, 1, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 4'h1, 1, 0, 0);
        b_st = st_fires;
        step(0, 1, 4'h1, 1, 0, 0);
        chk("s3_plain_store", 64'(st_fires - b_st), 64'd1);
        step(0, 1, 4'h3, 1, 0, 0);
        step(0, 1, 4'h3, 1, 1, 0);
        chk("s3_amo_blocked", 64'(st_fires - b_st), 64'd1);
        step(0, 1, 4'h3, 1, 0, 0);
        step(0, 1, 4'h3, 1, 0, 0);
        chk("s3_amo_once", 64'(st_fires - b_st), 64'd2);
        // Take and response together at credits=5 leave five credits.
        step(0, 0, 4'h1, 1, 0, 1);
        b_ld = ld_fires;
        for (int i = 0; i < 3; i++) step(1, 0, 4'h1, 1, 0, 0);
        step(1, 0, 4'h1, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 4'h1, 1, 0, 0);
        chk("s4_credit_hold", 64'(ld_fires - b_ld), 64'd9);
        // Unexpected response at full credits sets a sticky error.
        step(0, 0, 4'h1, 1, 0, 1);
        step(0, 0, 4'h1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'h1, 1, 0, 0);
        chk("s5_err_sticky", 64'(credit_err), 64'd1);
        step(0, 0, 4'h1, 1, 0, 1);
        chk("s5_err_reset", 64'(credit_err), 64'd0);
        // Mid-operation reset with credits=2 and starve_cnt=3.
        for (int i = 0; i < 6; i++) step(1, 0, 4'h1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 4'h1, 1, 0, 0);
        step(0, 0, 4'h1, 1, 0, 1);
        chk("s6_idle_after_reset", 64'(arb_idle), 64'd1);
        step(0, 0, 4'h1, 1, 0, 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 2))
                0: rop = 4'h1;
                1: rop = 4'h3;
                default: rop = 4'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rop,
                 $urandom_range(0, 3) != 0, outst > 0 && $urandom_range(0, 2) == 0,
                 $urandom_range(0, 499) == 0);
        end
        step(0, 0, 4'h1, 1, 0, 0);
        @(negedge clk);
        #1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
